// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-beat memory slave for a valid/ready bus. Each accepted request goes
// through a fixed number of wait states. It is then answered with a one-cycle
// ready pulse. A read also updates the registered rdata.
//
// Parameters
//   SZ           address width; memory depth is 2**SZ words
//   WIDTH        data width
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports
//   clk                in   rising-edge clock
//   rst                in   asynchronous reset, active low
//   valid              in   request present (sampled only while idle)
//   write_read_enable  in   1 = write, 0 = read
//   address            in   word address
//   wr_data            in   write data
//   rdata              out  read data, registered, held between read responses
//   ready              out  response strobe, registered, one cycle wide
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int SZ          = 4,
  parameter int WIDTH       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             write_read_enable,
  input  logic [SZ-1:0]    address,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rdata,
  output logic             ready
);

  localparam int DEPTH = 1 << SZ;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [SZ-1:0]    r_addr;
  logic             r_we;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ready;
  logic [WIDTH-1:0] r_rdata;

  logic             w_commit;

  // The memory write happens on the same edge that raises ready. This edge is
  // the one that leaves RESP. A read issued next therefore sees the new data.
  assign w_commit = (r_state == ST_RESP) && r_we;

  // Request capture and the wait-state sequencer. Bus inputs are looked at
  // only in IDLE. Churn during WAIT/RESP therefore cannot disturb the request
  // already in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid) begin
            r_addr  <= address;
            r_we    <= write_read_enable;
            r_wdata <= wr_data;
            r_cnt   <= WAIT_LOAD;
            r_state <= (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // When the count is 1, this is the last wait edge. The response then
          // follows on the next edge. As a result, ready lands at
          // accept + WAIT_CYCLES + 1.
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response outputs are driven straight from flops, with no path from the
  // inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= (r_state == ST_RESP);
      if ((r_state == ST_RESP) && !r_we) begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

  // The memory must be cleared on reset, so it is built from one resettable
  // register per word rather than from a RAM macro.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_mem[gi] <= '0;
      end else if (w_commit && (r_addr == SZ'(gi))) begin
        r_mem[gi] <= r_wdata;
      end
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. Two instances are used:
//   dut_a  WAIT_CYCLES = 2  (table-driven vectors plus multi-cycle corners)
//   dut_b  WAIT_CYCLES = 0  (zero-wait latency)
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// the same point.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic       clk;
  logic       rst;

  logic       valid_a, we_a;
  logic [3:0] addr_a;
  logic [7:0] wd_a, rdata_a;
  logic       ready_a;

  logic       valid_b, we_b;
  logic [3:0] addr_b;
  logic [7:0] wd_b, rdata_b;
  logic       ready_b;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder #(.SZ(4), .WIDTH(8), .WAIT_CYCLES(2)) dut_a (
    .clk               (clk),
    .rst               (rst),
    .valid             (valid_a),
    .write_read_enable (we_a),
    .address           (addr_a),
    .wr_data           (wd_a),
    .rdata             (rdata_a),
    .ready             (ready_a)
  );

  mem_responder #(.SZ(4), .WIDTH(8), .WAIT_CYCLES(0)) dut_b (
    .clk               (clk),
    .rst               (rst),
    .valid             (valid_b),
    .write_read_enable (we_b),
    .address           (addr_b),
    .wr_data           (wd_b),
    .rdata             (rdata_b),
    .ready             (ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic we,
                       input logic [3:0] a, input logic [7:0] d);
    if (sel == 0) begin
      valid_a = v; we_a = we; addr_a = a; wd_a = d;
    end else begin
      valid_b = v; we_b = we; addr_b = a; wd_b = d;
    end
  endtask

  function automatic logic cur_ready(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic [7:0] cur_rdata(input int sel);
    return (sel == 0) ? rdata_a : rdata_b;
  endfunction

  // Single request: the accept edge is T0. lat is the number of edges after
  // T0 until ready is seen (-1 on timeout). extra is ready one cycle later.
  task automatic run_txn(input int sel, input logic we, input logic [3:0] a,
                         input logic [7:0] d, output int lat,
                         output logic [7:0] rd, output logic extra);
    lat = -1;
    rd  = 8'h00;
    drive(sel, 1'b1, we, a, d);
    tick();
    drive(sel, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (cur_ready(sel)) begin
        lat = k;
        rd  = cur_rdata(sel);
        break;
      end
    end
    tick();
    extra = cur_ready(sel);
  endtask

  int         lat;
  logic [7:0] rd;
  logic       extra;
  int         first, second, pulses;
  logic [7:0] rd2;

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'd15, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 4'd3,  8'hA5, 8'h00};
    vecs[3]  = '{1'b0, 4'd3,  8'h00, 8'hA5};
    vecs[4]  = '{1'b1, 4'd5,  8'h77, 8'hA5};
    vecs[5]  = '{1'b1, 4'd15, 8'h3C, 8'hA5};
    vecs[6]  = '{1'b0, 4'd15, 8'h00, 8'h3C};
    vecs[7]  = '{1'b0, 4'd5,  8'h00, 8'h77};
    vecs[8]  = '{1'b1, 4'd0,  8'hFF, 8'h77};
    vecs[9]  = '{1'b0, 4'd0,  8'h00, 8'hFF};
    vecs[10] = '{1'b0, 4'd3,  8'h00, 8'hA5};

    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_ready_a", 32'(ready_a), 32'd0);
      chk("reset_rdata_a", 32'(rdata_a), 32'd0);
      chk("reset_ready_b", 32'(ready_b), 32'd0);
      chk("reset_rdata_b", 32'(rdata_b), 32'd0);
    end
    rst = 1'b1;
    $display("reset released");

    // Table-driven single transactions on the WAIT_CYCLES=2 instance
    for (int i = 0; i < 11; i++) begin
      run_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, extra);
      $display("txn %0d: %s addr=%0d wdata=0x%02h -> lat=%0d rdata=0x%02h",
               i, vecs[i].we ? "WR" : "RD", vecs[i].addr, vecs[i].wdata, lat, rd);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_ready_width", i), 32'(extra), 32'd0);
    end

    // rdata holds after the last read (address 3 = 0xA5) with valid low
    for (int i = 0; i < 3; i++) tick();
    chk("rdata_hold", 32'(rdata_a), 32'hA5);
    $display("hold check: rdata=0x%02h after 3 idle cycles", rdata_a);

    // Back-to-back: valid is kept high, then switched to a read in the ready cycle
    first = -1; second = -1; rd2 = 8'h00; rd = 8'h00;
    drive(0, 1'b1, 1'b1, 4'd1, 8'h11);
    tick();
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ready_a) begin
        if (first < 0) begin
          first = c;
          rd = rdata_a;
          drive(0, 1'b1, 1'b0, 4'd1, 8'h00);
        end else if (second < 0) begin
          second = c;
          rd2 = rdata_a;
        end
      end
      if (first >= 0 && c == first + 1) drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    end
    $display("back-to-back: first ready at %0d, second at %0d, rdata=0x%02h", first, second, rd2);
    chk("b2b_first_latency", 32'(first), 32'd3);
    chk("b2b_write_rdata_unchanged", 32'(rd), 32'hA5);
    chk("b2b_spacing", 32'(second - first), 32'd4);
    chk("b2b_read_rdata", 32'(rd2), 32'h11);

    // Input churn: a read of address 3 is accepted, then the inputs change during WAIT
    pulses = 0; lat = -1; rd = 8'h00;
    drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
    tick();
    drive(0, 1'b0, 1'b1, 4'd5, 8'hEE);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ready_a) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          rd = rdata_a;
        end
      end
    end
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    $display("churn: pulses=%0d lat=%0d rdata=0x%02h", pulses, lat, rd);
    chk("churn_pulses", 32'(pulses), 32'd1);
    chk("churn_latency", 32'(lat), 32'd3);
    chk("churn_rdata", 32'(rd), 32'hA5);
    run_txn(0, 1'b0, 4'd5, 8'h00, lat, rd, extra);
    $display("churn follow-up read addr=5 -> rdata=0x%02h", rd);
    chk("churn_addr5_untouched", 32'(rd), 32'h77);

    // Reset mid-request: write 0x5A to address 7, then reset one cycle after accept
    drive(0, 1'b1, 1'b1, 4'd7, 8'h5A);
    tick();
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready", 32'(ready_a), 32'd0);
    chk("midrst_rdata", 32'(rdata_a), 32'd0);
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ready_a) pulses++;
    end
    chk("midrst_no_ready", 32'(pulses), 32'd0);
    run_txn(0, 1'b0, 4'd7, 8'h00, lat, rd, extra);
    $display("mid-reset: read addr=7 -> lat=%0d rdata=0x%02h", lat, rd);
    chk("midrst_read_latency", 32'(lat), 32'd3);
    chk("midrst_read_rdata", 32'(rd), 32'h00);

    // Zero wait-state instance
    run_txn(1, 1'b1, 4'd3, 8'hA5, lat, rd, extra);
    $display("w0 txn: WR addr=3 wdata=0xa5 -> lat=%0d rdata=0x%02h", lat, rd);
    chk("w0_write_latency", 32'(lat), 32'd1);
    chk("w0_write_rdata", 32'(rd), 32'h00);
    chk("w0_write_ready_width", 32'(extra), 32'd0);
    run_txn(1, 1'b0, 4'd3, 8'h00, lat, rd, extra);
    $display("w0 txn: RD addr=3 -> lat=%0d rdata=0x%02h", lat, rd);
    chk("w0_read_latency", 32'(lat), 32'd1);
    chk("w0_read_rdata", 32'(rd), 32'hA5);
    chk("w0_read_ready_width", 32'(extra), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
